// File: rtl/share_recombiner.sv
// share_recombiner: terminal stage of a masked pipeline. Registers the
// Boolean shares as a glitch barrier, XOR-recombines the registered
// shares, buffers the unmasked result in a small FIFO and releases it on
// a valid/ready handshake.
module share_recombiner #(
   parameter int unsigned SHARES = 2,
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned DEPTH  = 3
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [SHARES*WIDTH-1:0]     in_shares,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [WIDTH-1:0]            out_data,
   output logic [$clog2(DEPTH+2)-1:0]  occupancy
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned OW = $clog2(DEPTH + 2);

   logic                    s1_valid_q,  s1_valid_d;
   logic [SHARES*WIDTH-1:0] s1_shares_q, s1_shares_d;
   logic [PW-1:0]           wr_ptr_q,    wr_ptr_d;
   logic [PW-1:0]           rd_ptr_q,    rd_ptr_d;
   logic [CW-1:0]           count_q,     count_d;
   logic [WIDTH-1:0]        mem_q [DEPTH];

   logic             in_fire;
   logic             push;
   logic             pop;
   logic [WIDTH-1:0] recomb;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Credit-based accept: a slot is free when the staged value plus the
   // buffered values leave room, so the stage-1 write never has to stall.
   assign occupancy = OW'(s1_valid_q) + OW'(count_q);
   assign in_ready  = !rst && (occupancy < OW'(DEPTH));
   assign in_fire   = in_valid && in_ready;
   assign push      = s1_valid_q;
   assign out_valid = (count_q != '0);
   assign pop       = out_valid && out_ready;
   assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

   // Recombine only the registered shares; no share mixing before stage 1.
   always_comb begin
      recomb = '0;
      for (int unsigned i = 0; i < SHARES; i++) begin
         recomb = recomb ^ s1_shares_q[i*WIDTH +: WIDTH];
      end
   end

   // Next-state for the barrier stage, pointers and FIFO count.
   always_comb begin
      s1_valid_d  = in_fire;
      s1_shares_d = in_fire ? in_shares : s1_shares_q;
      wr_ptr_d    = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d    = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      count_d     = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Control and share registers; reset discards any in-flight value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_shares_q <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_shares_q <= s1_shares_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
      end
   end

   // FIFO storage: tail written whenever stage 1 holds a value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q <= '{default: '0};
      end else if (push) begin
         mem_q[wr_ptr_q] <= recomb;
      end
   end

endmodule

// File: doc/share_recombiner.md
Name: share_recombiner

Overview:
- Terminal stage of a masked gadget pipeline: accepts a SHARES-way Boolean-shared value and emits the unmasked value.
- Input shares are first captured in a glitch-barrier register stage; only after that are they XOR-recombined.
- The recombined value is buffered in a small FIFO and leaves on a valid/ready handshake.
- Sits between the last masked gadget register and any unmasked consumer (checker, output port, bus).

Parameters:
- SHARES, 2, number of Boolean shares (≥2).
- WIDTH, 8, bits per share and per unmasked output.
- DEPTH, 3, output FIFO entries. Must be ≥3 for full throughput; legal range 1..8.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_shares holds a valid shared value.
- in_ready  out  1  block can accept an input this cycle.
- in_shares  in  SHARES*WIDTH  share i occupies bits [i*WIDTH +: WIDTH].
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts out_data this cycle.
- out_data  out  WIDTH  unmasked value, the XOR of all shares.
- occupancy  out  $clog2(DEPTH+2)  s1_valid + fifo_count, for debug.

Behaviour:
- Reset is asynchronous, active-high and may assert at any cycle.
  - Clears s1_valid, the FIFO pointers and fifo_count.
  - Zeroes the share register s1_shares and all FIFO data.
  - While in reset: in_ready=0, out_valid=0, out_data=0, occupancy=0.
  - An in-flight value is discarded, with no partial output.
  - The first cycle after deassertion has in_ready=1.
- Input handshake:
  - A transfer occurs when in_valid && in_ready.
  - in_ready = (occupancy < DEPTH). It depends on registers only, with no combinational path from out_ready or in_valid.
- Stage 1 (glitch barrier):
  - On transfer, all SHARES*WIDTH bits are captured into s1_shares and s1_valid is set.
  - Without a transfer, s1_valid clears the cycle after its content moves to the FIFO.
  - s1_shares holds its old value when not loading; it is never zeroed except by reset.
  - No logic may combine different shares before this register.
- Stage 2 (recombine + FIFO):
  - When s1_valid=1, XOR of all s1_shares slices is written to the FIFO tail that cycle.
  - Space is guaranteed by the in_ready credit rule, so the write never stalls.
  - The XOR is a pure tree over registered shares only.
- Output:
  - out_valid = (fifo_count != 0).
  - out_data = FIFO head, or 0 when empty.
  - Pop when out_valid && out_ready.
  - out_data must remain stable while out_valid && !out_ready.
- Latency: input accepted at edge t yields out_valid=1 in the cycle after edge t+1, i.e. 2 cycles, when the FIFO was empty.
- Throughput: with DEPTH≥3 and out_ready held 1, one value per cycle indefinitely.
- Simultaneous FIFO write and pop: fifo_count is unchanged.
  - A write to an empty FIFO with out_ready=1 still yields one visible out_valid cycle; there is no bypass.
- Pointers:
  - Read/write pointers wrap modulo DEPTH.
  - fifo_count is held explicitly, so full/empty is unambiguous for non-power-of-two DEPTH.
- Ordering is strictly FIFO; no value is dropped or duplicated.
- Backpressure: with out_ready=0, at most DEPTH values are accepted. in_ready then stays 0 until a pop occurs.
- in_shares is ignored when no transfer occurs.

Test Plan:
- Reset then single value:
  - Stimulus: after rst, in_shares={8'h3C,8'h5A} with in_valid=1 for 1 cycle, out_ready=1.
  - Response: out_data=8'h66 with out_valid=1 exactly 2 cycles after acceptance, for exactly 1 cycle.
- Streaming:
  - Stimulus: 16 consecutive inputs of random share pairs, unmasked values 0..15, out_ready=1, DEPTH=3.
  - Response: in_ready is never 0; outputs are 0..15 in order on consecutive cycles.
- Backpressure/full:
  - Stimulus: out_ready=0, push values A1,B2,C3,D4.
  - Response: A1,B2,C3 accepted; in_ready=0 from then on and D4 is held off; occupancy=3.
  - Then raise out_ready: outputs A1,B2,C3,D4 in order, and out_data is stable while stalled.
- Reset mid-operation:
  - Stimulus: assert rst asynchronously mid-cycle while 2 entries are buffered and s1 is loaded.
  - Response: out_valid=0 and occupancy=0 immediately; after release no stale value ever appears.
- Parameter sweep:
  - Stimulus: SHARES=4, WIDTH=16, DEPTH=5, random shares.
  - Response: out_data equals the XOR of all 4 shares.
  - Stimulus: DEPTH=5 with 5 stalled values.
  - Response: the FIFO wraps correctly and keeps order.
- Simultaneous push/pop at full:
  - Stimulus: occupancy=DEPTH with out_ready=1.
  - Response: in_ready=0 that cycle and 1 next cycle; nothing is lost or duplicated.
